// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word width, divider FSM states and constants.
package cpu_pkg;

  localparam int WORD_SIZE = 19;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Quotient reported when the divisor is zero.
  localparam word_t DIV_ZERO_QUOTIENT = '1;

  // Step counter wide enough to count WORD_SIZE restoring steps.
  localparam int STEP_CNT_W = $clog2(WORD_SIZE);
  typedef logic [STEP_CNT_W-1:0] step_cnt_t;
  localparam step_cnt_t LAST_STEP = step_cnt_t'(WORD_SIZE - 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module div_step
  import cpu_pkg::*;
(
  input  logic [WORD_SIZE:0]   partial,
  input  logic                 dq_msb,
  input  logic [WORD_SIZE-1:0] divisor,
  output logic [WORD_SIZE:0]   partial_next,
  output logic                 q_bit
);

  logic [WORD_SIZE:0]   shifted;
  logic [WORD_SIZE+1:0] diff;

  // Trial subtraction; a set partial MSB means the shifted value already
  // exceeds any divisor, so subtraction is forced (never happens while the
  // partial remainder stays below the divisor).
  always_comb begin
    shifted      = {partial[WORD_SIZE-1:0], dq_msb};
    diff         = {1'b0, shifted} - {2'b00, divisor};
    q_bit        = ~diff[WORD_SIZE+1] | partial[WORD_SIZE];
    partial_next = q_bit ? diff[WORD_SIZE:0] : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock, with
// valid/ready request and result handshakes.
module seq_divider
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WORD_SIZE-1:0] dividend,
  input  logic [WORD_SIZE-1:0] divisor,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [WORD_SIZE-1:0] quotient,
  output logic [WORD_SIZE-1:0] remainder,
  output logic                 div_by_zero
);

  div_state_t         state_q, state_d;
  word_t              dq_q, dq_d;
  word_t              divisor_q, divisor_d;
  logic [WORD_SIZE:0] partial_q, partial_d;
  step_cnt_t          count_q, count_d;
  word_t              quotient_q, quotient_d;
  word_t              remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WORD_SIZE:0] step_partial;
  logic               step_q_bit;
  logic               accept;
  logic               last_step;

  div_step u_div_step (
    .partial      (partial_q),
    .dq_msb       (dq_q[WORD_SIZE-1]),
    .divisor      (divisor_q),
    .partial_next (step_partial),
    .q_bit        (step_q_bit)
  );

  assign accept    = start_valid && (state_q == IDLE);
  assign last_step = (count_q == LAST_STEP);

  // FSM state register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero divisor skips the step loop entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the registered state.
  always_comb begin
    start_ready  = (state_q == IDLE);
    result_valid = (state_q == DONE);
  end

  // Datapath next values: operand capture, per-step shift, result capture.
  always_comb begin
    dq_d        = dq_q;
    divisor_d   = divisor_q;
    partial_d   = partial_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (accept) begin
      dq_d      = dividend;
      divisor_d = divisor;
      partial_d = '0;
      count_d   = '0;
      if (divisor == '0) begin
        quotient_d  = DIV_ZERO_QUOTIENT;
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end
    end else if (state_q == CALC) begin
      dq_d      = {dq_q[WORD_SIZE-2:0], step_q_bit};
      partial_d = step_partial;
      count_d   = count_q + step_cnt_t'(1);
      if (last_step) begin
        quotient_d  = {dq_q[WORD_SIZE-2:0], step_q_bit};
        remainder_d = step_partial[WORD_SIZE-1:0];
        dbz_d       = 1'b0;
      end
    end
  end

  // Datapath and result registers; results clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q        <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      dq_q        <= dq_d;
      divisor_q   <= divisor_d;
      partial_q   <= partial_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized
// operands and handshake stalls against a plain-arithmetic reference.
module tb_seq_divider;
  import cpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_valid;
  logic                 start_ready;
  logic [WORD_SIZE-1:0] dividend;
  logic [WORD_SIZE-1:0] divisor;
  logic                 result_valid;
  logic                 result_ready;
  logic [WORD_SIZE-1:0] quotient;
  logic [WORD_SIZE-1:0] remainder;
  logic                 div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for start_ready, pass the accept edge,
  // then scramble the operand inputs to show they are ignored afterwards.
  task automatic issue(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b);
    int guard;
    guard       = 0;
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    while (!start_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_value("accept_ready", start_ready, 1);
    tick();
    start_valid = 1'b0;
    dividend    = WORD_SIZE'($urandom);
    divisor     = WORD_SIZE'($urandom);
  endtask

  // Full transaction: issue, wait for result, check against the reference,
  // hold result_ready low for 'stall' cycles, then consume.
  task automatic run_op(input string tag, input logic [WORD_SIZE-1:0] a,
                        input logic [WORD_SIZE-1:0] b, input int stall);
    logic [WORD_SIZE-1:0] exp_q;
    logic [WORD_SIZE-1:0] exp_r;
    logic                 exp_z;
    int                   exp_lat;
    int                   lat;
    int unsigned          ua;
    int unsigned          ub;
    ua = int'(a);
    ub = int'(b);
    if (ub == 0) begin
      exp_q   = '1;
      exp_r   = a;
      exp_z   = 1'b1;
      exp_lat = 0;
    end else begin
      exp_q   = WORD_SIZE'(ua / ub);
      exp_r   = WORD_SIZE'(ua % ub);
      exp_z   = 1'b0;
      exp_lat = WORD_SIZE;
    end
    issue(a, b);
    lat = 0;
    while (!result_valid && lat < 40) begin
      check_value({tag, "_busy_ready"}, start_ready, 0);
      tick();
      lat++;
    end
    check_value({tag, "_valid"}, result_valid, 1);
    check_value({tag, "_latency"}, lat, exp_lat);
    check_value({tag, "_ready_in_done"}, start_ready, 0);
    check_value({tag, "_quot"}, quotient, exp_q);
    check_value({tag, "_rem"}, remainder, exp_r);
    check_value({tag, "_dbz"}, div_by_zero, exp_z);
    for (int i = 0; i < stall; i++) begin
      result_ready = 1'b0;
      tick();
      check_value({tag, "_hold_valid"}, result_valid, 1);
      check_value({tag, "_hold_quot"}, quotient, exp_q);
      check_value({tag, "_hold_rem"}, remainder, exp_r);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_value({tag, "_consumed"}, result_valid, 0);
    check_value({tag, "_idle_ready"}, start_ready, 1);
    $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d stall=%0d",
             tag, a, b, quotient, remainder, div_by_zero, lat, stall);
  endtask

  initial begin
    logic [WORD_SIZE-1:0] ra;
    logic [WORD_SIZE-1:0] rb;
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    dividend     = '0;
    divisor      = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_value("rst_start_ready", start_ready, 1);
    check_value("rst_result_valid", result_valid, 0);
    check_value("rst_quot", quotient, 0);
    check_value("rst_rem", remainder, 0);
    check_value("rst_dbz", div_by_zero, 0);

    run_op("d_100_7", 19'd100, 19'd7, 0);
    run_op("d_max_1", 19'h7FFFF, 19'd1, 0);
    run_op("d_5_9", 19'd5, 19'd9, 0);
    run_op("d_1234_0", 19'd1234, 19'd0, 0);
    run_op("d_hold", 19'd54321, 19'd123, 10);

    // Asynchronous reset in the middle of the step loop.
    issue(19'h40000, 19'd3);
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    check_value("midrst_valid", result_valid, 0);
    check_value("midrst_quot", quotient, 0);
    check_value("midrst_rem", remainder, 0);
    check_value("midrst_dbz", div_by_zero, 0);
    #3;
    rst = 1'b0;
    tick();
    check_value("midrst_ready", start_ready, 1);
    repeat (25) tick();
    check_value("midrst_no_result", result_valid, 0);
    $display("midrst: 0x40000 / 3 aborted at step 8");
    run_op("d_21_4", 19'd21, 19'd4, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = WORD_SIZE'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = WORD_SIZE'($urandom_range(1, 15));
        2:       rb = ra;
        3:       rb = WORD_SIZE'(ra >> $urandom_range(1, 18));
        default: rb = WORD_SIZE'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) tick();
      run_op("rand", ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
